// File: rtl/draw_sequencer.sv
// draw_sequencer: per-line tile fetch scheduler for the tile draw pipeline.
// A line pulse starts a walk over one line's tile fetches for the line after
// the one being displayed. Frame-latched scroll is applied, and one fetch is
// issued per cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no walk in progress; waiting for a line pulse with enable high
// START | one cycle; line_start is raised to reset the downstream stages
// FETCH | one fetch per cycle for k = 0..n-1; k == n closes out the walk
module draw_sequencer #(
  parameter int CORDW   = 11,
  parameter int FETCHES = 40
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             line,
  input  logic             frame,
  input  logic [CORDW-1:0] sy,
  input  logic             enable,
  input  logic [10:0]      scroll_x,
  input  logic [9:0]       scroll_y,
  output logic             line_start,
  output logic             fetch_valid,
  output logic [4:0]       tile_y,
  output logic [2:0]       tile_row,
  output logic [4:0]       tile_x,
  output logic             tile_col,
  output logic [10:0]      lb_x,
  output logic             bufsel,
  output logic             busy,
  output logic             overrun
);

  localparam int KW = $clog2(FETCHES + 2);
  localparam logic [KW-1:0] N_COARSE = KW'(FETCHES);
  localparam logic [KW-1:0] N_FINE   = KW'(FETCHES + 1);

  typedef enum logic [1:0] {IDLE, START, FETCH} state_t;

  state_t        state;
  logic [10:0]   sx_l;
  logic [9:0]    sy_l;
  logic [7:0]    dy_q;     // dy[9:2]; the two low bits never reach an output
  logic [5:0]    col0;
  logic [10:0]   lb0;
  logic [KW-1:0] n;
  logic [KW-1:0] k;

  logic [10:0]   sx_eff;
  logic [9:0]    sy_eff;
  logic [7:0]    dy_next;
  logic [5:0]    col_k;
  logic [10:0]   lb_k;
  logic          walk_active;

  // Scroll seen by a line starting this cycle: a coincident frame pulse wins.
  always_comb begin
    sx_eff  = frame ? scroll_x : sx_l;
    sy_eff  = frame ? scroll_y : sy_l;
    dy_next = 8'((10'(sy) + 10'd1 + sy_eff) >> 2);
    col_k   = col0 + 6'(k);
    lb_k    = lb0 + 11'({k, 4'b0000});
    // Once k reaches n every fetch has been issued, so a line arriving then
    // is on time rather than an overrun.
    walk_active = (state == START) || ((state == FETCH) && (k != n));
  end

  // Sequencer: scroll latch, walk control, overrun flag and registered fetch fields.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state       <= IDLE;
      sx_l        <= '0;
      sy_l        <= '0;
      dy_q        <= '0;
      col0        <= '0;
      lb0         <= '0;
      n           <= '0;
      k           <= '0;
      line_start  <= 1'b0;
      fetch_valid <= 1'b0;
      tile_y      <= '0;
      tile_row    <= '0;
      tile_x      <= '0;
      tile_col    <= 1'b0;
      lb_x        <= '0;
      bufsel      <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      line_start <= 1'b0;

      if (frame) begin
        sx_l <= scroll_x;
        sy_l <= scroll_y;
      end

      if (line && walk_active)
        overrun <= 1'b1;
      else if (frame)
        overrun <= 1'b0;

      if (line && enable) begin
        state       <= START;
        dy_q        <= dy_next;
        col0        <= 6'(sx_eff[10:4]);
        lb0         <= 11'd0 - 11'(sx_eff[3:0]);
        n           <= (sx_eff[3:0] != 4'd0) ? N_FINE : N_COARSE;
        bufsel      <= sy[0];
        k           <= '0;
        busy        <= 1'b1;
        fetch_valid <= 1'b0;
      end else if (line && walk_active) begin
        state       <= IDLE;
        busy        <= 1'b0;
        fetch_valid <= 1'b0;
      end else begin
        case (state)
          START: begin
            line_start <= 1'b1;
            state      <= FETCH;
          end
          FETCH: begin
            if (k == n) begin
              fetch_valid <= 1'b0;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              fetch_valid <= 1'b1;
              tile_y      <= dy_q[7:3];
              tile_row    <= dy_q[2:0];
              tile_x      <= col_k[5:1];
              tile_col    <= col_k[0];
              lb_x        <= lb_k;
              k           <= k + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Per-line scheduler for the tile draw pipeline. It replaces the free-running address counters in the first draw stage. On every line pulse from the VGA timing generator it walks one line's tile fetches, which render the line after the one being displayed. It applies frame-latched horizontal and vertical scroll and emits one fetch per cycle to the tile BRAM / quadrupler / aligner chain. It also produces the line-start reset for the downstream stages and the draw buffer select, and flags lines whose fetch walk did not finish before the next line began.

## Interface
- CORDW, 11, screen coordinate width
- FETCHES, 40, fetches per line with zero fine scroll (each fetch covers 16 line-buffer pixels)

- clk_pix  in  1  pixel clock; the only clock
- rst_pix  in  1  reset; asynchronous, active-high
- line  in  1  one-cycle pulse at the start of each line (from the VGA timing generator)
- frame  in  1  one-cycle pulse at the start of each frame
- sy  in  CORDW  line currently being displayed, sampled on `line`
- enable  in  1  permits starting new lines
- scroll_x  in  11  horizontal scroll in screen pixels, latched on `frame`
- scroll_y  in  10  vertical scroll in source lines, latched on `frame`
- line_start  out  1  one-cycle pulse before the first fetch; resets the downstream draw stages
- fetch_valid  out  1  fetch fields are valid this cycle
- tile_y  out  5  tile row index
- tile_row  out  3  pixel row within the tile
- tile_x  out  5  tile column index
- tile_col  out  1  which half of the tile's 8 pixels (4-pixel group)
- lb_x  out  11  line-buffer x of this fetch's first output pixel, mod 2048
- bufsel  out  1  sy[0] captured on `line`; held constant for the whole walk
- busy  out  1  high in START or FETCH
- overrun  out  1  sticky; set when a line starts before the previous walk has completed

## Operation
- States: IDLE, START, FETCH.
- Frame latch: on `frame`, capture scroll_x into sx_l and scroll_y into sy_l.
  - If `frame` and `line` occur in the same cycle, the new scroll values apply to that line.
- IDLE:
  - `line` with enable=1 → START.
  - On entry to START, compute and register:
    - dy = (sy[9:0] + 1 + sy_l) mod 1024
    - col0 = sx_l[10:4] mod 64
    - lb0 = (0 − sx_l[3:0]) mod 2048
    - n = FETCHES + (sx_l[3:0] ≠ 0)
    - capture bufsel = sy[0]
  - k ← 0.
  - `line` with enable=0: stay in IDLE.
- START: line_start=1 for exactly one cycle → FETCH.
- FETCH: one fetch per cycle, for k = 0..n−1:
  - tile_y = dy[9:5]
  - tile_row = dy[4:2] (each source row is repeated 4 times)
  - {tile_x, tile_col} = (col0 + k) mod 64, which wraps from 31/1 to 0/0
  - lb_x = lb0 + 16k, mod 2048
  - After k = n−1, go to IDLE.
- `line` during START or FETCH:
  - set overrun;
  - abandon the current walk;
  - restart per the IDLE rule, or go to IDLE if enable=0.
- enable dropping mid-walk: the current walk completes; no new walk starts.
- overrun clears only on `frame` or reset. If `frame` and a set condition occur in the same cycle, set wins.
- Reset: state IDLE; all outputs 0; sx_l, sy_l, k all 0.

## Timing
- `line` sampled high at edge t:
  - line_start=1 after edge t+1;
  - fetch k is presented after edge t+2+k;
  - busy falls and fetch_valid=0 after edge t+2+n.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- fetch_valid is low whenever it is not in FETCH. Address fields hold their last values and are don't-care.
- Minimum line period for overrun-free operation is n+2 cycles.
- Reset is asynchronous: outputs go to 0 without waiting for a clock edge, even mid-walk.

## Test plan
- Basic line:
  - Stimulus: scroll_x=0, scroll_y=0 latched; `line` with sy=9.
  - Response: line_start at t+1, then 40 fetches. Every fetch has tile_y=0, tile_row=2, bufsel=1. {tile_x, tile_col} runs 0/0, 0/1, 1/0 … 19/1. lb_x runs 0, 16 … 624. busy drops at t+42.
- Fine scroll:
  - Stimulus: scroll_x=0x025.
  - Response: 41 fetches. lb_x starts at 2043, then 11, 27 … The first fetch is tile_x=1, tile_col=0; the last is tile_x=21, tile_col=0.
- Column wrap:
  - Stimulus: scroll_x=0x7F0.
  - Response: 40 fetches. The first is tile_x=31, tile_col=1; the second is tile_x=0, tile_col=0. lb_x starts at 0.
- Vertical and frame coincidence:
  - Stimulus: `frame` and `line` in the same cycle, with scroll_y=0x3E0 and sy=31.
  - Response: dy=0, so tile_y=0 and tile_row=0 on that very line.
- Overrun:
  - Stimulus: a second `line` arrives 20 cycles after the first; later, a `frame` pulse.
  - Response: overrun=1 from the next cycle onward. line_start pulses again and k restarts at 0. overrun stays high until the `frame` pulse, then clears.
- Reset and enable:
  - Stimulus: assert rst_pix at fetch k=10.
  - Response: all outputs are 0 immediately. After reset is released, a `line` with enable=0 produces no line_start and no fetches.
